// File: rtl/idr_fu.sv
// RV32M integer divide/remainder unit, radix-2 restoring, start/done handshake.
// Optional IDR_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
package idr_pkg;
  typedef enum logic [1:0] {
    IDR_DIV  = 2'd0,
    IDR_DIVU = 2'd1,
    IDR_REM  = 2'd2,
    IDR_REMU = 2'd3
  } idr_op_e;
endpackage

module idr_fu
  import idr_pkg::*;
#(
  parameter int RSZ = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic [RSZ-1:0] Rs1_data,
  input  logic [RSZ-1:0] Rs2_data,
  input  idr_op_e        op,
  input  logic           start,
  output logic [RSZ-1:0] quotient,
  output logic [RSZ-1:0] remainder,
  output logic           done
);

  localparam int CW = $clog2(RSZ + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_e;

  state_e         state_q;
  logic [RSZ:0]   rem_q;
  logic [RSZ-1:0] dvd_q;
  logic [RSZ-1:0] dvs_q;
  logic [RSZ-1:0] quo_q;
  logic [RSZ-1:0] rmd_q;
  logic [CW-1:0]  cnt_q;
  logic           negq_q;
  logic           negr_q;
  logic           done_q;

  logic           sgn_op;
  logic           a_neg;
  logic           b_neg;
  logic [RSZ-1:0] a_mag;
  logic [RSZ-1:0] b_mag;
  logic           div_zero;
  logic           ovf;
  logic           early;
  logic [RSZ+1:0] shl;
  logic [RSZ+1:0] diff;
  logic           fits;

  always_comb begin
    sgn_op   = (op == IDR_DIV) || (op == IDR_REM);
    a_neg    = sgn_op & Rs1_data[RSZ-1];
    b_neg    = sgn_op & Rs2_data[RSZ-1];
    a_mag    = a_neg ? (~Rs1_data + 1'b1) : Rs1_data;
    b_mag    = b_neg ? (~Rs2_data + 1'b1) : Rs2_data;
    div_zero = (Rs2_data == '0);
    ovf      = sgn_op
             && (Rs1_data == {1'b1, {(RSZ-1){1'b0}}})
             && (Rs2_data == '1);
`ifdef IDR_EARLY_OUT_EN
    early    = !div_zero && (a_mag < b_mag);
`else
    early    = 1'b0;
`endif
  end

  // Full remainder feeds the shift so the borrow bit is exact.
  always_comb begin
    shl  = {rem_q, dvd_q[RSZ-1]};
    diff = shl - {2'b00, dvs_q};
    fits = !diff[RSZ+1];
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (div_zero) begin
              quo_q   <= '1;
              rmd_q   <= Rs1_data;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (ovf) begin
              quo_q   <= {1'b1, {(RSZ-1){1'b0}}};
              rmd_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (early) begin
              quo_q   <= '0;
              rmd_q   <= Rs1_data;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rem_q   <= '0;
              dvd_q   <= a_mag;
              dvs_q   <= b_mag;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              cnt_q   <= CW'(RSZ);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (fits) begin
            rem_q <= diff[RSZ:0];
            dvd_q <= {dvd_q[RSZ-2:0], 1'b1};
          end else begin
            rem_q <= shl[RSZ:0];
            dvd_q <= {dvd_q[RSZ-2:0], 1'b0};
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (cnt_q <= CW'(1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          quo_q   <= negq_q ? (~dvd_q + 1'b1) : dvd_q;
          rmd_q   <= negr_q ? (~rem_q[RSZ-1:0] + 1'b1)
                            : rem_q[RSZ-1:0];
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_idr_fu.sv
// Scoreboard bench for idr_fu: random and directed divides vs. a reference model.
// Define IDR_EARLY_OUT_EN for both RTL and bench to test the early-out build.
module tb_idr_fu;
  import idr_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] Rs1_data = '0;
  logic [31:0] Rs2_data = '0;
  idr_op_e     op = IDR_DIV;
  logic        start = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;

  idr_fu #(.RSZ(32)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .Rs1_data  (Rs1_data),
    .Rs2_data  (Rs2_data),
    .op        (op),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Quotient rounds toward zero, remainder takes the dividend's sign.
  function automatic void ref_model(input idr_op_e o, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r,
                                    output int lat);
    bit sg;
    logic [31:0] ma, mb;
    sg  = (o == IDR_DIV) || (o == IDR_REM);
    lat = 34;
    ma  = (sg && a[31]) ? -a : a;
    mb  = (sg && b[31]) ? -b : b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; lat = 1;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
`ifdef IDR_EARLY_OUT_EN
    if (b != 0 && ma < mb) lat = 1;
`else
    if (ma == mb) lat = lat;
`endif
  endfunction

  always @(negedge clk_in) begin
    if (!reset_in && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 at cyc %0d want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input idr_op_e o, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_it);
    logic [31:0] q, r;
    int lat;
    op = o; Rs1_data = a; Rs2_data = b; start = 1'b1;
    if (expect_it) begin
      ref_model(o, a, b, q, r, lat);
      sb.push_back('{q: q, r: r, due: cyc + lat});
    end
    @(posedge clk_in);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(negedge clk_in);
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done after %0d cycles want done", bound);
      sb.delete();
    end
    @(negedge clk_in);
  endtask

  task automatic run(input idr_op_e o, input logic [31:0] a,
                     input logic [31:0] b);
    @(negedge clk_in);
    drive(o, a, b, 1'b1);
    wait_idle(60);
  endtask

  function automatic logic [31:0] rnd_val(input int kind);
    logic [31:0] v;
    logic [31:0] edges [6];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
              32'h7FFF_FFFF, 32'hFFFF_FFFE};
    unique case (kind)
      0: v = $urandom;
      1: v = $urandom_range(0, 20);
      2: v = -$urandom_range(1, 20);
      3: v = edges[$urandom_range(0, 5)];
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] q0, r0;
    int l0;
    repeat (2) @(negedge clk_in);
    check("reset_quotient", quotient, 32'h0);
    check("reset_remainder", remainder, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    reset_in = 1'b0;
    @(negedge clk_in);

    run(IDR_DIV, 32'd100, 32'd7);
    run(IDR_DIV, 32'hFFFF_FFF9, 32'd2);
    run(IDR_DIVU, 32'hFFFF_FFFF, 32'd2);
    run(IDR_DIVU, 32'd5, 32'd0);
    run(IDR_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(IDR_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run(IDR_REMU, 32'd3, 32'd9);
    run(IDR_DIV, 32'hFFFF_FFF9, 32'd9);
    run(IDR_REM, 32'd7, 32'hFFFF_FFFE);
    run(IDR_REM, 32'hFFFF_FF9C, 32'd7);
    run(IDR_DIV, 32'd0, 32'd5);
    run(IDR_DIVU, 32'h8000_0000, 32'd1);
    run(IDR_DIV, 32'h8000_0000, 32'd1);

    // start during CALC is dropped
    @(negedge clk_in);
    drive(IDR_DIV, 32'd1000, 32'd7, 1'b1);
    repeat (8) @(negedge clk_in);
    drive(IDR_DIVU, 32'd999, 32'd4, 1'b0);
    wait_idle(60);
    repeat (40) @(negedge clk_in);
    check("busy_hold_q", quotient, 32'd142);
    check("busy_hold_r", remainder, 32'd6);

    // start in the DONE cycle is dropped
    @(negedge clk_in);
    drive(IDR_REMU, 32'd50, 32'd8, 1'b1);
    begin
      int k = 0;
      while (done !== 1'b1 && k < 60) begin
        @(negedge clk_in);
        k++;
      end
    end
    drive(IDR_DIVU, 32'd77, 32'd3, 1'b0);
    wait_idle(60);
    repeat (40) @(negedge clk_in);
    check("donecyc_hold_q", quotient, 32'd6);
    check("donecyc_hold_r", remainder, 32'd2);

    // reset mid-operation
    @(negedge clk_in);
    drive(IDR_DIV, 32'd12345, 32'd11, 1'b1);
    repeat (4) @(negedge clk_in);
    reset_in = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_q", quotient, 32'h0);
    check("rst_mid_r", remainder, 32'h0);
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (40) @(negedge clk_in);
    run(IDR_DIV, 32'd12345, 32'd11);

    for (int i = 0; i < 150; i++) begin
      idr_op_e o;
      o = idr_op_e'($urandom_range(0, 3));
      run(o, rnd_val($urandom_range(0, 4)), rnd_val($urandom_range(0, 4)));
    end

    ref_model(IDR_DIVU, 32'd1, 32'd1, q0, r0, l0);
    check("model_sanity", q0, 32'd1);
    repeat (3) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
